vga_sync_gen: RTL and testbench



---
 rtl/vga_sync_gen.sv | 88 ++++++++
 tb/tb_vga_sync_gen.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// VGA timing generator: divides CLK to the pixel rate, runs the horizontal and
// vertical counters and drives registered sync pulses aligned with the counters.
module vga_sync_gen #(
  parameter int   CLK_DIV     = 4,
  parameter int   H_VISIBLE   = 640,
  parameter int   H_FP        = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BP        = 48,
  parameter int   V_VISIBLE   = 480,
  parameter int   V_FP        = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BP        = 33,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic       CLK,
  input  logic       RST,
  output logic       HS,
  output logic       VS,
  output logic       VIDEO_ON,
  output logic [9:0] ADDRH,
  output logic [9:0] ADDRV
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       H_LAST     = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0]       V_LAST     = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0]       H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0]       V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0]       H_SYNC_BEG = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0]       H_SYNC_END = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0]       V_SYNC_BEG = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0]       V_SYNC_END = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_q, h_d;
  logic [9:0]       v_q, v_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             tick;

  assign tick = (div_q == DIV_LAST);

  always_comb begin
    div_d = tick ? '0 : div_q + 1'b1;
    h_d   = h_q;
    v_d   = v_q;
    if (tick) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  // Sync is decoded from the next counter values so the registered pulse lines
  // up with the counters shown in the same cycle.
  always_comb begin
    hs_d = ((h_d >= H_SYNC_BEG) && (h_d < H_SYNC_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vs_d = ((v_d >= V_SYNC_BEG) && (v_d < V_SYNC_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
      hs_q  <= ~SYNC_ACTIVE;
      vs_q  <= ~SYNC_ACTIVE;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
    end
  end

  assign HS       = hs_q;
  assign VS       = vs_q;
  assign ADDRH    = h_q;
  assign ADDRV    = v_q;
  assign VIDEO_ON = (h_q < H_VIS) && (v_q < V_VIS);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default timing, CLK_DIV=1 line timing and a shrunken
// geometry that allows whole frames, mid-frame resets and random reset stress.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_def = 1'b1, rst_d1 = 1'b1, rst_sm = 1'b1;
  logic       def_hs, def_vs, def_von, d1_hs, d1_vs, d1_von, sm_hs, sm_vs, sm_von;
  logic [9:0] def_h, def_v, d1_h, d1_v, sm_h, sm_v;

  int passed = 0;
  int total  = 0;

  vga_sync_gen u_def (
    .CLK(clk), .RST(rst_def), .HS(def_hs), .VS(def_vs), .VIDEO_ON(def_von),
    .ADDRH(def_h), .ADDRV(def_v)
  );

  vga_sync_gen #(.CLK_DIV(1)) u_d1 (
    .CLK(clk), .RST(rst_d1), .HS(d1_hs), .VS(d1_vs), .VIDEO_ON(d1_von),
    .ADDRH(d1_h), .ADDRV(d1_v)
  );

  vga_sync_gen #(
    .CLK_DIV(2), .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VISIBLE(5), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_ACTIVE(1'b1)
  ) u_sm (
    .CLK(clk), .RST(rst_sm), .HS(sm_hs), .VS(sm_vs), .VIDEO_ON(sm_von),
    .ADDRH(sm_h), .ADDRV(sm_v)
  );

  typedef struct {
    int          edges;
    logic [22:0] exp;
  } vec_t;

  function automatic logic [22:0] pk(int h, int v, bit hs, bit vs, bit von);
    return {10'(h), 10'(v), hs, vs, von};
  endfunction

  // Reference: position is simply (clocks since reset / CLK_DIV) laid out
  // row-major over an h_total x v_total raster.
  function automatic logic [22:0] ref_out(int c, int div, int hv, int hfp, int hsy, int hbp,
                                          int vv, int vfp, int vsy, int vbp, bit sa);
    int p, ht, vt, h, v;
    bit hs, vs, von;
    ht  = hv + hfp + hsy + hbp;
    vt  = vv + vfp + vsy + vbp;
    p   = c / div;
    h   = p % ht;
    v   = (p / ht) % vt;
    hs  = (h >= hv + hfp && h < hv + hfp + hsy) ? sa : !sa;
    vs  = (v >= vv + vfp && v < vv + vfp + vsy) ? sa : !sa;
    von = (h < hv) && (v < vv);
    return pk(h, v, hs, vs, von);
  endfunction

  task automatic chk(input string nm, input logic [22:0] act, input logic [22:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got h=%0d v=%0d hs=%b vs=%b von=%b, expected h=%0d v=%0d hs=%b vs=%b von=%b",
                  nm, act[22:13], act[12:3], act[2], act[1], act[0],
                  exp[22:13], exp[12:3], exp[2], exp[1], exp[0]);
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // Default-geometry vectors: {edges since reset release, expected outputs}.
  task automatic run_def();
    vec_t vt[14];
    int   ec;
    vt[0]  = '{0,     pk(0,   0,  1, 1, 1)};
    vt[1]  = '{3,     pk(0,   0,  1, 1, 1)};
    vt[2]  = '{4,     pk(1,   0,  1, 1, 1)};
    vt[3]  = '{2559,  pk(639, 0,  1, 1, 1)};
    vt[4]  = '{2560,  pk(640, 0,  1, 1, 0)};
    vt[5]  = '{2623,  pk(655, 0,  1, 1, 0)};
    vt[6]  = '{2624,  pk(656, 0,  0, 1, 0)};
    vt[7]  = '{3007,  pk(751, 0,  0, 1, 0)};
    vt[8]  = '{3008,  pk(752, 0,  1, 1, 0)};
    vt[9]  = '{3199,  pk(799, 0,  1, 1, 0)};
    vt[10] = '{3200,  pk(0,   1,  1, 1, 1)};
    vt[11] = '{35196, pk(799, 10, 1, 1, 0)};
    vt[12] = '{35199, pk(799, 10, 1, 1, 0)};
    vt[13] = '{35200, pk(0,   11, 1, 1, 1)};
    rst_def = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    ec = 0;
    for (int i = 0; i < 14; i++) begin
      while (ec < vt[i].edges) begin
        @(posedge clk);
        ec++;
      end
      if (ec > 0) #2;
      chk($sformatf("def_vec%0d", i), {def_h, def_v, def_hs, def_vs, def_von}, vt[i].exp);
      rst_def = 1'b0;
    end
  endtask

  task automatic run_d1();
    int hs_low;
    rst_d1 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("d1_reset", {d1_h, d1_v, d1_hs, d1_vs, d1_von}, pk(0, 0, 1, 1, 1));
    rst_d1 = 1'b0;
    hs_low = 0;
    for (int e = 1; e <= 800; e++) begin
      @(posedge clk);
      #2;
      if (d1_hs == 1'b0) hs_low++;
      if (e == 1 || e == 655 || e == 656 || e == 751 || e == 752 || e == 800)
        chk($sformatf("d1_edge%0d", e), {d1_h, d1_v, d1_hs, d1_vs, d1_von},
            ref_out(e, 1, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
    end
    chk_int("d1_hs_low_clocks", hs_low, 96);
  endtask

  // Small geometry: 15x10 raster, CLK_DIV=2, active-high sync; frame = 300 clocks.
  int sm_c = 0;
  bit sm_mon_en = 1'b0;

  always @(posedge clk) sm_c <= rst_sm ? 0 : sm_c + 1;

  always @(negedge clk)
    if (sm_mon_en)
      chk("sm_model", {sm_h, sm_v, sm_hs, sm_vs, sm_von},
          ref_out(sm_c, 2, 8, 2, 3, 2, 5, 1, 2, 2, 1'b1));

  task automatic sm_adv(inout int ec, input int target);
    while (ec < target) begin
      @(posedge clk);
      ec++;
    end
    #2;
  endtask

  task automatic run_sm();
    int ec, first_vs, second_vs;
    bit prev_vs;
    rst_sm = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    sm_mon_en = 1'b1;
    chk("sm_reset", {sm_h, sm_v, sm_hs, sm_vs, sm_von}, pk(0, 0, 0, 0, 1));
    rst_sm = 1'b0;
    ec = 0;
    first_vs = -1;
    second_vs = -1;
    prev_vs = 1'b0;
    while (ec < 1000 && second_vs < 0) begin
      @(posedge clk);
      ec++;
      #2;
      if (!prev_vs && sm_vs) begin
        if (first_vs < 0) first_vs = ec;
        else second_vs = ec;
      end
      prev_vs = sm_vs;
    end
    chk_int("sm_first_vs_edge", first_vs, 180);
    chk_int("sm_frame_clocks", second_vs - first_vs, 300);
    sm_adv(ec, 599);
    chk("sm_frame_end", {sm_h, sm_v, sm_hs, sm_vs, sm_von}, pk(14, 9, 0, 0, 0));
    sm_adv(ec, 600);
    chk("sm_frame_wrap", {sm_h, sm_v, sm_hs, sm_vs, sm_von}, pk(0, 0, 0, 0, 1));
    sm_adv(ec, 836);
    chk("sm_pre_abort", {sm_h, sm_v, sm_hs, sm_vs, sm_von}, pk(13, 7, 0, 1, 0));
    rst_sm = 1'b1;
    @(posedge clk);
    #2;
    chk("sm_abort", {sm_h, sm_v, sm_hs, sm_vs, sm_von}, pk(0, 0, 0, 0, 1));
    rst_sm = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("sm_resume", {sm_h, sm_v, sm_hs, sm_vs, sm_von}, pk(1, 0, 0, 0, 1));
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(1, 350)) @(posedge clk);
      #2;
      rst_sm = 1'b1;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #2;
      rst_sm = 1'b0;
    end
    repeat (400) @(posedge clk);
    @(negedge clk);
    sm_mon_en = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    fork
      run_def();
      run_d1();
      run_sm();
    join
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
